// File: rtl/axil_master_convert_pkg.sv
// Shared types and constants for the local-request to AXI-Lite master bridge.
// Data/strobe widths, AXI response codes and FSM state encodings live here.
package axil_master_convert_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Returned to the local side when a read gives up waiting on the slave.
  localparam logic [AXIL_DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2,
    W_ACK  = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_ACK  = 2'd3
  } rd_state_e;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & RESP_SLVERR) != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_master_convert_timer.sv
// Response timeout down-counter, one instance per direction.
// Reloads whenever its FSM is not in a waiting state; expires at terminal count.
module axil_cvt_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else if (!run_i) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/axil_master_convert.sv
// Local addr/data/valid/ready requests to AXI-Lite master, independent write/read FSMs.
// Define AXIL_CVT_TIMEOUT_EN to add per-direction response timeouts and idle B/R draining.
//
// state  | meaning
// W_IDLE | waiting for wvalid
// W_REQ  | presenting AW and W until both are accepted
// W_RESP | waiting for the B beat
// W_ACK  | one-cycle wready pulse
// R_IDLE | waiting for rvalid
// R_ADDR | presenting AR until accepted
// R_DATA | waiting for the R beat
// R_ACK  | one-cycle rready pulse
module axil_master_convert
  import axil_master_convert_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIL_ADDR_WIDTH-1:0] waddr,
  input  logic [AXIL_DATA_WIDTH-1:0] wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic                       wr_err,
  input  logic [AXIL_ADDR_WIDTH-1:0] raddr,
  input  logic                       rvalid,
  output logic [AXIL_DATA_WIDTH-1:0] rdata,
  output logic                       rready,
  output logic                       rd_err,
  output logic [AXIL_ADDR_WIDTH-1:0] awaddr_m,
  output logic                       awvalid_m,
  input  logic                       awready_m,
  output logic [AXIL_DATA_WIDTH-1:0] wdata_m,
  output logic [AXIL_STRB_WIDTH-1:0] wstrb_m,
  output logic                       wvalid_m,
  input  logic                       wready_m,
  input  logic [1:0]                 bresp_m,
  input  logic                       bvalid_m,
  output logic                       bready_m,
  output logic [AXIL_ADDR_WIDTH-1:0] araddr_m,
  output logic                       arvalid_m,
  input  logic                       arready_m,
  input  logic [AXIL_DATA_WIDTH-1:0] rdata_m,
  input  logic [1:0]                 rresp_m,
  input  logic                       rvalid_m,
  output logic                       rready_m
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [AXIL_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q;
  logic [AXIL_STRB_WIDTH-1:0] wstrb_q;
  logic                       aw_done_q;
  logic                       w_done_q;
  logic                       wr_err_q;
  logic [AXIL_ADDR_WIDTH-1:0] araddr_q;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q;
  logic                       rd_err_q;
  logic                       drain_q;

  logic wr_timeout;
  logic rd_timeout;
  logic aw_hs;
  logic w_hs;

`ifdef AXIL_CVT_TIMEOUT_EN
  localparam bit DRAIN_IDLE = 1'b1;

  axil_cvt_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wr_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     ((wr_state_q == W_REQ) || (wr_state_q == W_RESP)),
    .expired_o (wr_timeout)
  );

  axil_cvt_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     ((rd_state_q == R_ADDR) || (rd_state_q == R_DATA)),
    .expired_o (rd_timeout)
  );
`else
  localparam bit DRAIN_IDLE = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // Held low through reset so every output reads 0 until the bridge is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drain_q <= 1'b0;
    else        drain_q <= DRAIN_IDLE;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state_q <= W_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  assign aw_hs = awvalid_m && awready_m;
  assign w_hs  = wvalid_m && wready_m;

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE: if (wvalid) wr_state_d = W_REQ;
      W_REQ: begin
        if (wr_timeout)                                 wr_state_d = W_ACK;
        else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = W_RESP;
      end
      W_RESP: if (wr_timeout || bvalid_m) wr_state_d = W_ACK;
      W_ACK:  wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid_m = 1'b0;
    wvalid_m  = 1'b0;
    bready_m  = 1'b0;
    wready    = 1'b0;
    unique case (wr_state_q)
      W_IDLE: bready_m = drain_q;
      W_REQ: begin
        awvalid_m = !aw_done_q && !wr_timeout;
        wvalid_m  = !w_done_q && !wr_timeout;
      end
      W_RESP: bready_m = !wr_timeout;
      W_ACK:  wready   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      if (wr_state_q == W_IDLE && wvalid) begin
        awaddr_q  <= waddr;
        wdata_q   <= wdata;
        wstrb_q   <= wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (wr_state_q == W_REQ) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (wr_timeout)                                wr_err_q <= 1'b1;
      else if (wr_state_q == W_RESP && bvalid_m)     wr_err_q <= resp_is_err(bresp_m);
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state_q <= R_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE: if (rvalid) rd_state_d = R_ADDR;
      R_ADDR: begin
        if (rd_timeout)     rd_state_d = R_ACK;
        else if (arready_m) rd_state_d = R_DATA;
      end
      R_DATA: if (rd_timeout || rvalid_m) rd_state_d = R_ACK;
      R_ACK:  rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid_m = 1'b0;
    rready_m  = 1'b0;
    rready    = 1'b0;
    unique case (rd_state_q)
      R_IDLE: rready_m  = drain_q;
      R_ADDR: arvalid_m = !rd_timeout;
      R_DATA: rready_m  = !rd_timeout;
      R_ACK:  rready    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q <= '0;
      rdata_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (rd_state_q == R_IDLE && rvalid) araddr_q <= raddr;
      if (rd_timeout) begin
        rdata_q  <= TIMEOUT_RDATA;
        rd_err_q <= 1'b1;
      end else if (rd_state_q == R_DATA && rvalid_m) begin
        rdata_q  <= rdata_m;
        rd_err_q <= resp_is_err(rresp_m);
      end
    end
  end

  assign awaddr_m = awaddr_q;
  assign wdata_m  = wdata_q;
  assign wstrb_m  = wstrb_q;
  assign wr_err   = wr_err_q;
  assign araddr_m = araddr_q;
  assign rdata    = rdata_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_axil_master_convert.sv
// Directed bench for axil_master_convert with a configurable-latency AXI-Lite slave.
// Covers the timeout path too when built with AXIL_CVT_TIMEOUT_EN.
module tb_axil_master_convert;

`ifdef AXIL_CVT_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, rvalid = 1'b0;
  logic        wready, wr_err, rready, rd_err;
  logic [31:0] rdata;
  logic [31:0] awaddr_m, wdata_m, araddr_m;
  logic [3:0]  wstrb_m;
  logic        awvalid_m, wvalid_m, bready_m, arvalid_m, rready_m;
  logic        awready_m = 1'b0, wready_m = 1'b0, bvalid_m = 1'b0;
  logic        arready_m = 1'b0, rvalid_m = 1'b0;
  logic [1:0]  bresp_m = '0, rresp_m = '0;
  logic [31:0] rdata_m = '0;

  always #5 clk = ~clk;

  axil_master_convert #(
    .AXIL_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .wr_err    (wr_err),
    .raddr     (raddr),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rready    (rready),
    .rd_err    (rd_err),
    .awaddr_m  (awaddr_m),
    .awvalid_m (awvalid_m),
    .awready_m (awready_m),
    .wdata_m   (wdata_m),
    .wstrb_m   (wstrb_m),
    .wvalid_m  (wvalid_m),
    .wready_m  (wready_m),
    .bresp_m   (bresp_m),
    .bvalid_m  (bvalid_m),
    .bready_m  (bready_m),
    .araddr_m  (araddr_m),
    .arvalid_m (arvalid_m),
    .arready_m (arready_m),
    .rdata_m   (rdata_m),
    .rresp_m   (rresp_m),
    .rvalid_m  (rvalid_m),
    .rready_m  (rready_m)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // slave configuration
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          b_never = 0, r_never = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  // slave state and monitor counters
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          wready_cnt = 0, rready_cnt = 0, viol = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [31:0] aw_hold_a = '0, w_hold_d = '0, ar_hold_a = '0;

  // Readies/valids change only at negedge; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready_m = 0; wready_m = 0; bvalid_m = 0; arready_m = 0; rvalid_m = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      if (aw_hold && (!awvalid_m || awaddr_m !== aw_hold_a)) viol++;
      if (w_hold && (!wvalid_m || wdata_m !== w_hold_d)) viol++;
      if (ar_hold && (!arvalid_m || araddr_m !== ar_hold_a)) viol++;

      if (awvalid_m) begin awready_m = (aw_wait >= aw_dly); aw_wait++; end
      else begin awready_m = 0; aw_wait = 0; end
      if (wvalid_m) begin wready_m = (w_wait >= w_dly); w_wait++; end
      else begin wready_m = 0; w_wait = 0; end
      if (bready_m && !b_never) begin bvalid_m = (b_wait >= b_dly); b_wait++; end
      else begin bvalid_m = 0; b_wait = 0; end
      bresp_m = b_resp_cfg;
      if (arvalid_m) begin arready_m = (ar_wait >= ar_dly); ar_wait++; end
      else begin arready_m = 0; ar_wait = 0; end
      if (rready_m && !r_never) begin rvalid_m = (r_wait >= r_dly); r_wait++; end
      else begin rvalid_m = 0; r_wait = 0; end
      rdata_m = r_data_cfg;
      rresp_m = r_resp_cfg;

      if (awvalid_m && awready_m) begin aw_cnt++; last_awaddr = awaddr_m; end
      if (wvalid_m && wready_m) begin w_cnt++; last_wdata = wdata_m; last_wstrb = wstrb_m; end
      if (bvalid_m && bready_m) b_cnt++;
      if (arvalid_m && arready_m) begin ar_cnt++; last_araddr = araddr_m; end
      if (rvalid_m && rready_m) r_cnt++;
      if (wready) wready_cnt++;
      if (rready) rready_cnt++;

      aw_hold = awvalid_m && !awready_m; aw_hold_a = awaddr_m;
      w_hold  = wvalid_m && !wready_m;   w_hold_d  = wdata_m;
      ar_hold = arvalid_m && !arready_m; ar_hold_a = araddr_m;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat, input logic exp_err);
    int lat;
    bit got;
    int aw0, w0, wr0;
    aw0 = aw_cnt; w0 = w_cnt; wr0 = wready_cnt;
    waddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      lat++;
      if (wready) got = 1;
    end
    wvalid = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(wr_err), 32'(exp_err));
    check({tag, "_aw_beats"}, 32'(aw_cnt - aw0), 32'd1);
    check({tag, "_w_beats"}, 32'(w_cnt - w0), 32'd1);
    check({tag, "_awaddr"}, last_awaddr, a);
    check({tag, "_wdata"}, last_wdata, d);
    check({tag, "_wstrb"}, 32'(last_wstrb), 32'(s));
    tick();
    check({tag, "_wready_pulses"}, 32'(wready_cnt - wr0), 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_lat, input logic exp_err);
    int lat;
    bit got;
    int ar0, rr0;
    ar0 = ar_cnt; rr0 = rready_cnt;
    raddr = a; rvalid = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      lat++;
      if (rready) got = 1;
    end
    rvalid = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rdata, exp_d);
    check({tag, "_err"}, 32'(rd_err), 32'(exp_err));
    check({tag, "_ar_beats"}, 32'(ar_cnt - ar0), 32'd1);
    check({tag, "_araddr"}, last_araddr, a);
    tick();
    check({tag, "_rready_pulses"}, 32'(rready_cnt - rr0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ar0, rr0, wr0;
    bit got;

    // reset values
    tick(); tick();
    check("rst_outputs", {awvalid_m, wvalid_m, bready_m, arvalid_m, rready_m, wready, rready,
                          wr_err, rd_err}, 32'd0);
    check("rst_addr_data", awaddr_m | wdata_m | araddr_m | rdata | 32'(wstrb_m), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // zero-wait write and read, minimum latency
    do_write("wr_zero", 32'h10, 32'hA5A5_0001, 4'hF, 3, 1'b0);
    r_data_cfg = 32'h0BAD_F00D;
    do_read("rd_zero", 32'h24, 32'h0BAD_F00D, 3, 1'b0);

    // AW accepted 4 cycles after W, SLVERR response
    aw_dly = 4; b_resp_cfg = 2'b10;
    do_write("wr_aw_late", 32'h14, 32'h0000_BEEF, 4'h3, 7, 1'b1);
    aw_dly = 0; b_resp_cfg = 2'b00;
    check("wr_err_hold", 32'(wr_err), 32'd1);

    // reset in the middle of a write: no completion pulse, captures cleared
    b_never = 1;
    waddr = 32'h18; wdata = 32'h1111_2222; wstrb = 4'h1; wvalid = 1'b1;
    tick(); tick(); tick();
    check("mid_rst_in_resp", 32'(bready_m), 32'd1);
    wr0 = wready_cnt;
    wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_quiet", {awvalid_m, wvalid_m, bready_m, wready, wr_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    b_never = 0;
    tick(); tick(); tick();
    check("mid_rst_no_pulse", 32'(wready_cnt - wr0), 32'd0);
    check("mid_rst_idle", {awvalid_m, wvalid_m}, 32'd0);

    // read with 5-cycle R delay
    r_dly = 5; r_data_cfg = 32'h1234_5678;
    do_read("rd_slow", 32'h20, 32'h1234_5678, 8, 1'b0);
    r_dly = 0;

    // DECERR read; error and data hold afterwards
    r_resp_cfg = 2'b11; r_data_cfg = 32'hBAD0_0001;
    do_read("rd_decerr", 32'h28, 32'hBAD0_0001, 3, 1'b1);
    r_resp_cfg = 2'b00;
    tick(); tick(); tick();
    check("rd_err_hold", 32'(rd_err), 32'd1);
    check("rdata_hold", rdata, 32'hBAD0_0001);

    // simultaneous write and read
    r_data_cfg = 32'h5555_AAAA; r_dly = 2; w_dly = 1;
    fork
      do_write("par_wr", 32'h30, 32'h0303_0303, 4'hC, 4, 1'b0);
      do_read("par_rd", 32'h34, 32'h5555_AAAA, 5, 1'b0);
    join
    r_dly = 0; w_dly = 0;

    // back-to-back reads with rvalid held
    ar0 = ar_cnt; rr0 = rready_cnt;
    r_data_cfg = 32'hCAFE_0001;
    raddr = 32'h40; rvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin tick(); if (rready) got = 1; end
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_rdata", rdata, 32'hCAFE_0001);
    raddr = 32'h44; r_data_cfg = 32'hCAFE_0002;
    tick();
    check("b2b_gap", {arvalid_m, rready}, 32'd0);
    tick();
    check("b2b_second_ar", 32'(arvalid_m), 32'd1);
    check("b2b_second_araddr", araddr_m, 32'h44);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin tick(); if (rready) got = 1; end
    rvalid = 1'b0;
    check("b2b_second_rdata", rdata, 32'hCAFE_0002);
    tick();
    check("b2b_ar_beats", 32'(ar_cnt - ar0), 32'd2);
    check("b2b_rready_pulses", 32'(rready_cnt - rr0), 32'd2);

`ifdef AXIL_CVT_TIMEOUT_EN
    // slave never answers B / R: give up TO cycles after leaving IDLE
    b_never = 1;
    do_write("wr_timeout", 32'h50, 32'h7777_0000, 4'hF, TO + 1, 1'b1);
    check("wr_idle_drain_ready", 32'(bready_m), 32'd1);
    begin
      int b0;
      b0 = b_cnt; wr0 = wready_cnt;
      b_never = 0;
      tick(); tick(); tick(); tick();
      check("wr_late_b_drained", 32'(b_cnt > b0), 32'd1);
      check("wr_late_b_no_pulse", 32'(wready_cnt - wr0), 32'd0);
      check("wr_late_b_idle", 32'(awvalid_m), 32'd0);
    end
    r_never = 1;
    do_read("rd_timeout", 32'h54, 32'hDEAD_BEEF, TO + 1, 1'b1);
    r_never = 0;
`endif

    tick(); tick();
    check("handshake_stability", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_master_convert.md
Name: axil_master_convert

Overview:
- Reverse bridge of the NIC's AXI-Lite slave front end: turns the simple local register request interface (addr/data/valid/ready) into AXI-Lite master transactions.
- Used by EthSubsystem engines (descriptor/config agents) that must program remote AXI-Lite register spaces.
- Independent write and read FSMs; one outstanding transaction per direction; captures responses and error status.

Parameters:
- AXIL_ADDR_WIDTH, 32, address width on both sides.
- TIMEOUT_CYCLES, 1024, response timeout limit; used only with the optional feature.
- Data/strobe widths come from `AXIL_DATA_WIDTH (32) / `AXIL_STRB_WIDTH (4) in eth_engine_def.vh.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
waddr  in  AXIL_ADDR_WIDTH  local write address
wdata  in  `AXIL_DATA_WIDTH  local write data
wstrb  in  `AXIL_STRB_WIDTH  local write strobes
wvalid  in  1  local write request, held until wready
wready  out  1  one-cycle completion pulse for the write
wr_err  out  1  valid with wready; 1 = SLVERR/DECERR/timeout
raddr  in  AXIL_ADDR_WIDTH  local read address
rvalid  in  1  local read request, held until rready
rdata  out  `AXIL_DATA_WIDTH  read data, valid with rready
rready  out  1  one-cycle completion pulse for the read
rd_err  out  1  valid with rready; 1 = error/timeout
awaddr_m  out  AXIL_ADDR_WIDTH  AXI AW address
awvalid_m  out  1  AW valid
awready_m  in  1  AW ready
wdata_m  out  `AXIL_DATA_WIDTH  AXI W data
wstrb_m  out  `AXIL_STRB_WIDTH  AXI W strobes
wvalid_m  out  1  W valid
wready_m  in  1  W ready
bresp_m  in  2  B response
bvalid_m  in  1  B valid
bready_m  out  1  B ready
araddr_m  out  AXIL_ADDR_WIDTH  AR address
arvalid_m  out  1  AR valid
arready_m  in  1  AR ready
rdata_m  in  `AXIL_DATA_WIDTH  R data
rresp_m  in  2  R response
rvalid_m  in  1  R valid
rready_m  out  1  R ready

Behaviour:
- Reset: all outputs 0, both FSMs in IDLE, all capture registers 0.
- Write FSM: W_IDLE, W_REQ, W_RESP, W_ACK.
  - W_IDLE with wvalid: register waddr/wdata/wstrb, clear aw_done/w_done, go to W_REQ.
  - W_REQ: awvalid_m = !aw_done, wvalid_m = !w_done; both are driven from registers and presented concurrently.
  - aw_done sets on the awvalid_m&&awready_m handshake; w_done sets on the wvalid_m&&wready_m handshake; either order, or the same cycle.
  - W_REQ exits to W_RESP in the cycle both handshakes are complete, counting one that completes in the current cycle.
  - W_RESP: bready_m=1; on bvalid_m, capture wr_err=bresp_m[1] and go to W_ACK.
  - W_ACK: wready=1 for exactly one cycle, then W_IDLE.
  - Minimum latency: wvalid seen at cycle 0, wready at cycle 3.
- Read FSM: R_IDLE, R_ADDR, R_DATA, R_ACK.
  - R_IDLE with rvalid: register raddr, go to R_ADDR.
  - R_ADDR: arvalid_m=1; on arready_m go to R_DATA.
  - R_DATA: rready_m=1; on rvalid_m, capture rdata=rdata_m and rd_err=rresp_m[1], go to R_ACK.
  - R_ACK: rready=1 for one cycle, then R_IDLE. Minimum latency is 3 cycles.
- rdata and wr_err/rd_err hold their value until the next capture.
- A request is not re-sampled during its own ACK cycle. A request still asserted in the cycle after the ACK is treated as a new transaction.
- Read and write are fully independent; simultaneous requests proceed in parallel with no ordering between them.
- AXI valid signals never drop before their ready. Address/data registers are stable for the whole transaction.
- Reset mid-transaction returns to IDLE immediately, with no completion pulse.

Optional Feature:
- AXIL_CVT_TIMEOUT_EN defined:
  - A per-FSM counter runs in REQ/ADDR/RESP/DATA states; it clears on entry to IDLE.
  - On reaching TIMEOUT_CYCLES, all AXI valid/ready outputs for that direction drop and the FSM goes to ACK with err=1.
  - For a timed-out read, rdata=32'hDEADBEEF.
  - In IDLE, bready_m/rready_m are held at 1 so late beats are drained and discarded.
- Undefined: no counter; the FSM waits indefinitely; bready_m/rready_m are 0 in IDLE.

Decomposition:
- Shared package/header eth_engine_def.vh: state encodings, `AXIL_DATA_WIDTH, `AXIL_STRB_WIDTH, `TD, and the AXI response codes OKAY=2'b00 and SLVERR=2'b10.
- No sub-module is required. Optionally factor out a shared timeout counter, axil_cvt_timer, instanced once per direction.

Test Plan:
- Write with zero-wait slave: waddr=0x10, wdata=0xA5A5_0001, wstrb=4'hF → one AW and one W beat with those values; wready at cycle 3; wr_err=0.
- AW ready 4 cycles after W ready; then bresp=2'b10 → awvalid_m held until accepted; single wready pulse with wr_err=1.
- Read raddr=0x20, slave returns 0x1234_5678 after 5-cycle R delay → rready pulse with rdata=0x1234_5678, rd_err=0; arvalid_m asserted exactly once.
- Simultaneous write 0x30 and read 0x34 → both complete independently; no cross-blocking.
- Back-to-back reads with rvalid held → two separate AR transactions, two rready pulses, second sampled only after R_ACK.
- With AXIL_CVT_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never returns B → wready with wr_err=1 at 16 cycles after W_REQ entry; late bvalid is drained in IDLE.
